// File: rtl/riscv_mem_pkg.sv
// Shared definitions for the bus-attached memory: response FSM states and
// the width of the wait-state counter.
package riscv_mem_pkg;

    localparam int WAIT_CNT_W = 4;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        WAIT = 2'd1,
        RESP = 2'd2
    } mem_state_e;

endpackage

// File: rtl/riscv_byte_ram.sv
// Single-port word array with per-byte write enables and a registered read.
// The read register only updates on a read, so its value holds between reads.
module riscv_byte_ram #(
    parameter string       MEMORY_FILENAME      = "",
    parameter int          MEMORY_WORDS         = 1024,
    parameter int          ADDR_W               = 10,
    parameter logic [31:0] DEFAULT_MEMORY_VALUE = 32'h0
) (
    input  logic              clk,
    input  logic              i_we,
    input  logic              i_re,
    input  logic [ADDR_W-1:0] i_addr,
    input  logic [3:0]        i_wstrb,
    input  logic [31:0]       i_wdata,
    output logic [31:0]       o_rdata
);

    logic [31:0] r_mem [0:MEMORY_WORDS-1];
    logic [31:0] r_rdata;

    // Power-up contents: every word starts at the default value.
    initial begin
        for (int i = 0; i < MEMORY_WORDS; i++) begin
            r_mem[i] = DEFAULT_MEMORY_VALUE;
        end
    end

    // NOTE: no reset on the array or its read register; a reset term here
    // would block block-RAM inference and contents must survive reset anyway.
    always_ff @(posedge clk) begin
        if (i_we) begin
            for (int b = 0; b < 4; b++) begin
                if (i_wstrb[b]) begin
                    r_mem[i_addr][8*b +: 8] <= i_wdata[8*b +: 8];
                end
            end
        end
        if (i_re) begin
            r_rdata <= r_mem[i_addr];
        end
    end

    assign o_rdata = r_rdata;

endmodule

// File: rtl/riscv_bus_memory.sv
// Valid/ready request, single-pulse response memory with a fixed number of
// wait states and address/alignment error reporting.
module riscv_bus_memory
    import riscv_mem_pkg::*;
#(
    parameter string       MEMORY_FILENAME      = "",
    parameter int          MEMORY_WORDS         = 1024,
    parameter logic [31:0] MEMORY_OFFSET        = 32'h0,
    parameter int          WAIT_STATES          = 0,
    parameter logic [31:0] DEFAULT_MEMORY_VALUE = 32'h0
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic        req_write,
    input  logic [31:0] req_addr,
    input  logic [31:0] req_wdata,
    input  logic [3:0]  req_wstrb,
    output logic        rsp_valid,
    output logic [31:0] rsp_rdata,
    output logic        rsp_error
);

    localparam int ADDR_W  = $clog2(MEMORY_WORDS);
    localparam int TAG_LSB = ADDR_W + 2;
    localparam logic [WAIT_CNT_W-1:0] WAIT_LOAD =
        (WAIT_STATES > 0) ? WAIT_CNT_W'(WAIT_STATES - 1) : '0;

    mem_state_e              r_state, w_state_nxt;
    logic [WAIT_CNT_W-1:0]   r_cnt, w_cnt_nxt;
    logic                    w_accept, w_enter_resp;
    logic                    r_write;
    logic [31:0]             r_addr, r_wdata;
    logic [3:0]              r_wstrb;
    logic                    w_acc_write, w_acc_ok, w_from_latch;
    logic [31:0]             w_acc_addr, w_acc_wdata;
    logic [3:0]              w_acc_wstrb;
    logic                    w_ram_we, w_ram_re;
    logic [31:0]             w_ram_rdata;
    logic                    r_rsp_error, r_rd_ok;

    assign req_ready = (r_state != WAIT);
    assign w_accept  = req_valid && req_ready;

    // NOTE: every output of this block gets a default first, so no path
    // through the case can leave a value unassigned and infer a latch.
    always_comb begin
        w_state_nxt  = r_state;
        w_cnt_nxt    = r_cnt;
        w_enter_resp = 1'b0;
        unique case (r_state)
            IDLE, RESP: begin
                if (w_accept) begin
                    if (WAIT_STATES == 0) begin
                        w_state_nxt  = RESP;
                        w_enter_resp = 1'b1;
                    end else begin
                        w_state_nxt = WAIT;
                        w_cnt_nxt   = WAIT_LOAD;
                    end
                end else begin
                    w_state_nxt = IDLE;
                end
            end
            WAIT: begin
                if (r_cnt == '0) begin
                    w_state_nxt  = RESP;
                    w_enter_resp = 1'b1;
                end else begin
                    w_cnt_nxt = r_cnt - 1'b1;
                end
            end
            default: w_state_nxt = IDLE;
        endcase
    end

    // Without wait states the access happens on the accepting edge itself,
    // so the live request is used; otherwise the latched copy.
    assign w_from_latch = (r_state == WAIT);
    assign w_acc_write  = w_from_latch ? r_write : req_write;
    assign w_acc_addr   = w_from_latch ? r_addr  : req_addr;
    assign w_acc_wdata  = w_from_latch ? r_wdata : req_wdata;
    assign w_acc_wstrb  = w_from_latch ? r_wstrb : req_wstrb;

    assign w_acc_ok = (w_acc_addr[31:TAG_LSB] == MEMORY_OFFSET[31:TAG_LSB]) &&
                      (w_acc_addr[1:0] == 2'b00);

    // The array has no reset of its own, so gate its enables while in reset.
    assign w_ram_we = rst_n && w_enter_resp && w_acc_ok && w_acc_write;
    assign w_ram_re = rst_n && w_enter_resp && w_acc_ok && !w_acc_write;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state     <= IDLE;
            r_cnt       <= '0;
            r_write     <= 1'b0;
            r_addr      <= '0;
            r_wdata     <= '0;
            r_wstrb     <= '0;
            r_rsp_error <= 1'b0;
            r_rd_ok     <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            r_cnt   <= w_cnt_nxt;
            if (w_accept) begin
                r_write <= req_write;
                r_addr  <= req_addr;
                r_wdata <= req_wdata;
                r_wstrb <= req_wstrb;
            end
            if (w_enter_resp) begin
                r_rsp_error <= !w_acc_ok;
                r_rd_ok     <= w_acc_ok && !w_acc_write;
            end
        end
    end

    riscv_byte_ram #(
        .MEMORY_FILENAME     (MEMORY_FILENAME),
        .MEMORY_WORDS        (MEMORY_WORDS),
        .ADDR_W              (ADDR_W),
        .DEFAULT_MEMORY_VALUE(DEFAULT_MEMORY_VALUE)
    ) u_ram (
        .clk    (clk),
        .i_we   (w_ram_we),
        .i_re   (w_ram_re),
        .i_addr (w_acc_addr[TAG_LSB-1:2]),
        .i_wstrb(w_acc_wstrb),
        .i_wdata(w_acc_wdata),
        .o_rdata(w_ram_rdata)
    );

    // Read data is only shown after a successful read; writes and errors read 0.
    assign rsp_valid = (r_state == RESP);
    assign rsp_error = r_rsp_error;
    assign rsp_rdata = r_rd_ok ? w_ram_rdata : 32'h0;

endmodule
